// File: rtl/axi_mem_slave_pkg.sv
// Shared constants and FSM encoding for the AXI4 memory responder.
// Optional feature macro: AXI_MEM_RANGE_ERR_EN (see axi_mem_slave.sv).
package axi_mem_slave_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_DATA  = 2'd2,
    ST_WR_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/iob_ram_sp_be.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port that holds its value whenever en is low.
module iob_ram_sp_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [DATA_W/8-1:0] we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array itself is never reset, so it maps onto block RAM and its
  // contents survive a reset; only the read register below is cleared.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < NB; b++) begin
        if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read-first: a write cycle returns the previous word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 slave serving one INCR burst at a time from an internal byte-enabled RAM.
// Define AXI_MEM_RANGE_ERR_EN to answer out-of-range bursts with SLVERR.
module axi_mem_slave
  import axi_mem_slave_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int MEM_ADDR_W = 16,
  parameter int AXI_ID_W   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  input  logic [AXI_ADDR_W-1:0]   axi_araddr,
  input  logic [7:0]              axi_arlen,
  input  logic [2:0]              axi_arsize,
  input  logic [1:0]              axi_arburst,
  input  logic [AXI_ID_W-1:0]     axi_arid,
  output logic                    axi_rvalid,
  output logic [AXI_DATA_W-1:0]   axi_rdata,
  output logic [1:0]              axi_rresp,
  output logic                    axi_rlast,
  output logic [AXI_ID_W-1:0]     axi_rid,
  input  logic                    axi_rready,
  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [AXI_ADDR_W-1:0]   axi_awaddr,
  input  logic [7:0]              axi_awlen,
  input  logic [2:0]              axi_awsize,
  input  logic [1:0]              axi_awburst,
  input  logic [AXI_ID_W-1:0]     axi_awid,
  input  logic                    axi_wvalid,
  input  logic [AXI_DATA_W-1:0]   axi_wdata,
  input  logic [AXI_DATA_W/8-1:0] axi_wstrb,
  input  logic                    axi_wlast,
  output logic                    axi_wready,
  output logic                    axi_bvalid,
  output logic [1:0]              axi_bresp,
  output logic [AXI_ID_W-1:0]     axi_bid,
  input  logic                    axi_bready
);

  localparam int BYTES = AXI_DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int WA_W  = MEM_ADDR_W - OFF_W;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [WA_W-1:0]     addr_q, addr_d;
  logic [AXI_ID_W-1:0] id_q, id_d;
  logic                err_q, err_d;
  logic                last_wr_q, last_wr_d;

  logic                ram_en;
  logic [BYTES-1:0]    ram_we;
  logic [WA_W-1:0]     ram_addr;
  logic [AXI_DATA_W-1:0] ram_rdata;

  logic [WA_W-1:0]     ar_word, aw_word;
  logic                ar_oor, aw_oor;
  logic                rd_grant, wr_grant;

  assign ar_word = axi_araddr[MEM_ADDR_W-1:OFF_W];
  assign aw_word = axi_awaddr[MEM_ADDR_W-1:OFF_W];

`ifdef AXI_MEM_RANGE_ERR_EN
  assign ar_oor = (axi_araddr >> MEM_ADDR_W) != '0;
  assign aw_oor = (axi_awaddr >> MEM_ADDR_W) != '0;
`else
  assign ar_oor = 1'b0;
  assign aw_oor = 1'b0;
`endif

  // On a tie the grant goes to the direction not taken last time.
  assign rd_grant = axi_arvalid & (~axi_awvalid | last_wr_q);
  assign wr_grant = axi_awvalid & (~axi_arvalid | ~last_wr_q);

  assign axi_arready = ~reset & (state_q == ST_IDLE) & rd_grant;
  assign axi_awready = ~reset & (state_q == ST_IDLE) & wr_grant;

  assign axi_rvalid = (state_q == ST_RD_BURST);
  assign axi_rlast  = axi_rvalid & (cnt_q == 8'd0);
  assign axi_rdata  = err_q ? '0 : ram_rdata;
  assign axi_rresp  = (axi_rvalid & err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign axi_rid    = id_q;
  assign axi_wready = (state_q == ST_WR_DATA);
  assign axi_bvalid = (state_q == ST_WR_RESP);
  assign axi_bresp  = (axi_bvalid & err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign axi_bid    = id_q;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    id_d      = id_q;
    err_d     = err_q;
    last_wr_d = last_wr_q;
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_addr  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (axi_arready) begin
          state_d   = ST_RD_BURST;
          cnt_d     = axi_arlen;
          addr_d    = ar_word + WA_W'(1);
          id_d      = axi_arid;
          err_d     = ar_oor;
          last_wr_d = 1'b0;
          ram_en    = 1'b1;
          ram_addr  = ar_word;
        end else if (axi_awready) begin
          state_d   = ST_WR_DATA;
          cnt_d     = axi_awlen;
          addr_d    = aw_word;
          id_d      = axi_awid;
          err_d     = aw_oor;
          last_wr_d = 1'b1;
        end
      end
      ST_RD_BURST: begin
        // The RAM read register doubles as the R output register.
        ram_en = ~axi_rvalid | axi_rready;
        if (axi_rready) begin
          if (cnt_q == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d  = cnt_q - 8'd1;
            addr_d = addr_q + WA_W'(1);
          end
        end
      end
      ST_WR_DATA: begin
        if (axi_wvalid) begin
          ram_en = 1'b1;
          ram_we = err_q ? '0 : axi_wstrb;
          addr_d = addr_q + WA_W'(1);
          if (cnt_q == 8'd0) state_d = ST_WR_RESP;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      ST_WR_RESP: begin
        if (axi_bready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      id_q      <= '0;
      err_q     <= 1'b0;
      last_wr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      err_q     <= err_d;
      last_wr_q <= last_wr_d;
    end
  end

  iob_ram_sp_be #(
    .DATA_W(AXI_DATA_W),
    .ADDR_W(WA_W)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(axi_wdata),
    .rdata(ram_rdata)
  );

  // Burst type, size, wlast and unbacked address bits carry no meaning here.
  logic unused_in;
  assign unused_in = ^{axi_araddr, axi_awaddr, axi_arsize, axi_awsize,
                       axi_arburst ^ AXI_BURST_INCR, axi_awburst, axi_wlast};

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed self-checking bench for axi_mem_slave (32-bit data, 16-bit RAM window).
module tb_axi_mem_slave;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAW = 16;
  localparam int IDW = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            axi_arvalid, axi_arready;
  logic [AW-1:0]   axi_araddr;
  logic [7:0]      axi_arlen;
  logic [2:0]      axi_arsize;
  logic [1:0]      axi_arburst;
  logic [IDW-1:0]  axi_arid;
  logic            axi_rvalid;
  logic [DW-1:0]   axi_rdata;
  logic [1:0]      axi_rresp;
  logic            axi_rlast;
  logic [IDW-1:0]  axi_rid;
  logic            axi_rready;
  logic            axi_awvalid, axi_awready;
  logic [AW-1:0]   axi_awaddr;
  logic [7:0]      axi_awlen;
  logic [2:0]      axi_awsize;
  logic [1:0]      axi_awburst;
  logic [IDW-1:0]  axi_awid;
  logic            axi_wvalid;
  logic [DW-1:0]   axi_wdata;
  logic [DW/8-1:0] axi_wstrb;
  logic            axi_wlast;
  logic            axi_wready;
  logic            axi_bvalid;
  logic [1:0]      axi_bresp;
  logic [IDW-1:0]  axi_bid;
  logic            axi_bready;

  int total = 0;
  int bad   = 0;

  // Captured read beats and handshake observations from the helper tasks.
  logic [31:0] rq_data[$];
  logic        rq_last[$];
  logic [1:0]  rq_resp[$];
  int          rq_off[$];
  logic [IDW-1:0] rq_id;
  bit          rd_unstable;
  logic        post_rvalid, post_bvalid;
  bit          wr_ready_bad;
  logic [IDW-1:0] wr_bid;

  always #5 clk = ~clk;

  axi_mem_slave #(
    .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .MEM_ADDR_W(MAW), .AXI_ID_W(IDW)
  ) dut (
    .clk(clk), .reset(reset),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arid(axi_arid), .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rid(axi_rid),
    .axi_rready(axi_rready), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awid(axi_awid), .axi_wvalid(axi_wvalid),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wready(axi_wready), .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp),
    .axi_bid(axi_bid), .axi_bready(axi_bready)
  );

  // Full write burst; beat i carries base+i. With skip_aw the caller has
  // already seen awready high in the current cycle.
  task automatic write_burst(input logic [31:0] addr, input int len,
                             input logic [31:0] base, input logic [3:0] strb,
                             input bit skip_aw, output bit ok,
                             output logic [1:0] bresp, output bit bv_timely);
    int n;
    ok = 1'b1; bresp = 2'bxx; bv_timely = 1'b0; wr_ready_bad = 1'b0; post_bvalid = 1'bx;
    if (!skip_aw) begin
      @(negedge clk);
      axi_awvalid = 1'b1; axi_awaddr = addr; axi_awlen = len[7:0]; #1;
      n = 0;
      while (!axi_awready && n < 20) begin @(negedge clk); #1; n++; end
      if (!axi_awready) begin ok = 1'b0; axi_awvalid = 1'b0; return; end
    end
    @(negedge clk);
    axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      axi_wvalid = 1'b1; axi_wdata = base + 32'(i); axi_wstrb = strb;
      axi_wlast = (i == len); #1;
      if (axi_wready !== 1'b1) wr_ready_bad = 1'b1;
      @(negedge clk);
    end
    axi_wvalid = 1'b0; axi_wlast = 1'b0; #1;
    bv_timely = axi_bvalid;
    n = 0;
    while (!axi_bvalid && n < 20) begin @(negedge clk); #1; n++; end
    if (!axi_bvalid) begin ok = 1'b0; return; end
    bresp = axi_bresp; wr_bid = axi_bid;
    axi_bready = 1'b1;
    @(negedge clk);
    axi_bready = 1'b0; #1;
    post_bvalid = axi_bvalid;
  endtask

  // Full read burst; toggle=1 holds rready low on odd cycles after the AR.
  task automatic read_burst(input logic [31:0] addr, input int len, input bit toggle,
                            input bit skip_ar, output bit ok);
    int n, off;
    bit stalled, done;
    logic [31:0] held;
    ok = 1'b1; done = 1'b0; stalled = 1'b0; held = '0; rd_unstable = 1'b0;
    post_rvalid = 1'bx; rq_id = 'x;
    rq_data.delete(); rq_last.delete(); rq_resp.delete(); rq_off.delete();
    if (!skip_ar) begin
      @(negedge clk);
      axi_arvalid = 1'b1; axi_araddr = addr; axi_arlen = len[7:0]; #1;
      n = 0;
      while (!axi_arready && n < 20) begin @(negedge clk); #1; n++; end
      if (!axi_arready) begin ok = 1'b0; axi_arvalid = 1'b0; return; end
    end
    @(negedge clk);
    axi_arvalid = 1'b0;
    off = 1;
    while (!done && off < 600) begin
      axi_rready = toggle ? (off % 2 == 0) : 1'b1; #1;
      if (stalled && axi_rvalid && axi_rdata !== held) rd_unstable = 1'b1;
      if (axi_rvalid && axi_rready) begin
        if (rq_data.size() == 0) rq_id = axi_rid;
        rq_data.push_back(axi_rdata); rq_last.push_back(axi_rlast);
        rq_resp.push_back(axi_rresp); rq_off.push_back(off);
        if (axi_rlast) done = 1'b1;
      end
      stalled = axi_rvalid && !axi_rready;
      held = axi_rdata;
      @(negedge clk);
      off++;
    end
    axi_rready = 1'b0;
    if (!done) ok = 1'b0;
    else begin #1; post_rvalid = axi_rvalid; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    axi_arvalid = 1'b1; axi_awvalid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if ({axi_arready, axi_awready} !== 2'b00) begin bad++;
      $display("FAIL reset_ready: got ar=%b aw=%b want 0 0", axi_arready, axi_awready); end
    total++; if ({axi_rvalid, axi_rlast, axi_wready, axi_bvalid} !== 4'b0000) begin bad++;
      $display("FAIL reset_valid: got rv=%b rl=%b wr=%b bv=%b want 0", axi_rvalid, axi_rlast, axi_wready, axi_bvalid); end
    total++; if ({axi_rdata, axi_rresp, axi_rid, axi_bresp, axi_bid} !== '0) begin bad++;
      $display("FAIL reset_data: got rdata=%h rresp=%b rid=%b bresp=%b bid=%b want 0",
               axi_rdata, axi_rresp, axi_rid, axi_bresp, axi_bid); end
    axi_arvalid = 1'b0; axi_awvalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_tie();
    bit ok, bvt;
    logic [1:0] br;
    // First tie after reset: write wins, read follows once the write is done.
    @(negedge clk);
    axi_arvalid = 1'b1; axi_araddr = 32'h40; axi_arlen = 8'd0;
    axi_awvalid = 1'b1; axi_awaddr = 32'h40; axi_awlen = 8'd0; #1;
    total++; if ({axi_awready, axi_arready} !== 2'b10) begin bad++;
      $display("FAIL tie1_grant: got aw=%b ar=%b want aw=1 ar=0", axi_awready, axi_arready); end
    write_burst(32'h40, 0, 32'hC0DE0040, 4'hF, 1'b1, ok, br, bvt);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL tie1_write: timeout got %b want 1", ok); end
    total++; if (axi_arready !== 1'b1) begin bad++;
      $display("FAIL tie1_read_second: arready got %b want 1", axi_arready); end
    read_burst(32'h40, 0, 1'b0, 1'b1, ok);
    total++; if (ok !== 1'b1 || rq_data[0] !== 32'hC0DE0040) begin bad++;
      $display("FAIL tie1_read_data: got %h want c0de0040", rq_data[0]); end
    // Last grant was read, so write wins again; then read wins the next tie.
    @(negedge clk);
    axi_arvalid = 1'b1; axi_araddr = 32'h44; axi_arlen = 8'd0;
    axi_awvalid = 1'b1; axi_awaddr = 32'h44; axi_awlen = 8'd0; #1;
    total++; if ({axi_awready, axi_arready} !== 2'b10) begin bad++;
      $display("FAIL tie2_grant: got aw=%b ar=%b want aw=1 ar=0", axi_awready, axi_arready); end
    axi_arvalid = 1'b0;
    write_burst(32'h44, 0, 32'h0000BEEF, 4'hF, 1'b1, ok, br, bvt);
    @(negedge clk);
    axi_arvalid = 1'b1; axi_araddr = 32'h44; axi_arlen = 8'd0;
    axi_awvalid = 1'b1; #1;
    total++; if ({axi_awready, axi_arready} !== 2'b01) begin bad++;
      $display("FAIL tie3_grant: got aw=%b ar=%b want aw=0 ar=1", axi_awready, axi_arready); end
    axi_awvalid = 1'b0;
    read_burst(32'h44, 0, 1'b0, 1'b1, ok);
    total++; if (ok !== 1'b1 || rq_data[0] !== 32'h0000BEEF) begin bad++;
      $display("FAIL tie3_read_data: got %h want 0000beef", rq_data[0]); end
  endtask

  task automatic test_write_read();
    bit ok, bvt;
    logic [1:0] br;
    axi_awid = 1'b1; axi_arid = 1'b1;
    write_burst(32'h100, 3, 32'hA0, 4'hF, 1'b0, ok, br, bvt);
    total++; if (ok !== 1'b1 || wr_ready_bad) begin bad++;
      $display("FAIL wr_handshake: ok=%b wready_low=%b want ok=1 wready_low=0", ok, wr_ready_bad); end
    total++; if (bvt !== 1'b1 || br !== 2'b00) begin bad++;
      $display("FAIL wr_bresp: bvalid_next=%b bresp=%b want 1 00", bvt, br); end
    total++; if (wr_bid !== 1'b1 || post_bvalid !== 1'b0) begin bad++;
      $display("FAIL wr_bid_turn: bid=%b bvalid_after=%b want 1 0", wr_bid, post_bvalid); end
    // Next AR must be accepted in the first cycle back in IDLE.
    axi_arvalid = 1'b1; axi_araddr = 32'h100; axi_arlen = 8'd3; #0;
    total++; if (axi_arready !== 1'b1) begin bad++;
      $display("FAIL wr_to_ar_turnaround: arready got %b want 1", axi_arready); end
    read_burst(32'h100, 3, 1'b0, 1'b1, ok);
    total++; if (ok !== 1'b1 || rq_data.size() != 4) begin bad++;
      $display("FAIL rd_beats: got %0d beats want 4", rq_data.size()); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (rq_data[k] !== 32'hA0 + 32'(k) || rq_last[k] !== (k == 3) ||
          rq_off[k] != k + 1 || rq_resp[k] !== 2'b00) begin
        bad++;
        $display("FAIL rd_beat%0d: data=%h last=%b cyc=%0d resp=%b want %h %b %0d 00",
                 k, rq_data[k], rq_last[k], rq_off[k], rq_resp[k], 32'hA0 + 32'(k), k == 3, k + 1);
      end
    end
    total++; if (rq_id !== 1'b1 || post_rvalid !== 1'b0) begin bad++;
      $display("FAIL rd_rid_turn: rid=%b rvalid_after=%b want 1 0", rq_id, post_rvalid); end
    axi_awid = 1'b0; axi_arid = 1'b0;
  endtask

  task automatic test_strobes();
    bit ok, bvt;
    logic [1:0] br;
    write_burst(32'h20, 0, 32'hFFFFFFFF, 4'hF, 1'b0, ok, br, bvt);
    write_burst(32'h20, 0, 32'h12345678, 4'b0101, 1'b0, ok, br, bvt);
    read_burst(32'h20, 0, 1'b0, 1'b0, ok);
    total++; if (ok !== 1'b1 || rq_data[0] !== 32'hFF34FF78) begin bad++;
      $display("FAIL strobe_merge: got %h want ff34ff78", rq_data[0]); end
  endtask

  task automatic test_backpressure();
    bit ok, bvt, seq_bad;
    logic [1:0] br;
    write_burst(32'h200, 7, 32'hB0, 4'hF, 1'b0, ok, br, bvt);
    read_burst(32'h200, 7, 1'b1, 1'b0, ok);
    total++; if (ok !== 1'b1 || rq_data.size() != 8) begin bad++;
      $display("FAIL bp_beats: got %0d beats want 8", rq_data.size()); end
    seq_bad = 1'b0;
    for (int k = 0; k < 8; k++)
      if (rq_data[k] !== 32'hB0 + 32'(k) || rq_last[k] !== (k == 7)) seq_bad = 1'b1;
    total++; if (seq_bad) begin bad++;
      $display("FAIL bp_sequence: first=%h last=%h want b0..b7 with rlast on beat 7", rq_data[0], rq_data[7]); end
    total++; if (rd_unstable) begin bad++;
      $display("FAIL bp_stall_hold: rdata changed while stalled got 1 want 0"); end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    @(negedge clk);
    axi_arvalid = 1'b1; axi_araddr = 32'h100; axi_arlen = 8'd7; #1;
    total++; if (axi_arready !== 1'b1) begin bad++;
      $display("FAIL rst_mid_ar: arready got %b want 1", axi_arready); end
    @(negedge clk);
    axi_arvalid = 1'b0; axi_rready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1; #1;
    total++; if ({axi_arready, axi_awready, axi_rvalid, axi_rlast, axi_wready, axi_bvalid} !== 6'b0) begin bad++;
      $display("FAIL rst_mid_outputs: got ar=%b aw=%b rv=%b rl=%b wr=%b bv=%b want 0",
               axi_arready, axi_awready, axi_rvalid, axi_rlast, axi_wready, axi_bvalid); end
    axi_rready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    read_burst(32'h100, 3, 1'b0, 1'b0, ok);
    total++; if (ok !== 1'b1 || rq_data.size() != 4 || rq_data[0] !== 32'hA0 || rq_data[3] !== 32'hA3) begin bad++;
      $display("FAIL rst_mid_retained: beats=%0d first=%h last=%h want 4 a0 a3",
               rq_data.size(), rq_data[0], rq_data[3]); end
  endtask

`ifdef AXI_MEM_RANGE_ERR_EN
  task automatic test_range_err();
    bit ok, bvt;
    logic [1:0] br;
    write_burst(32'h0, 0, 32'h5A5A0000, 4'hF, 1'b0, ok, br, bvt);
    read_burst(32'h1 << MAW, 1, 1'b0, 1'b0, ok);
    total++; if (ok !== 1'b1 || rq_data.size() != 2) begin bad++;
      $display("FAIL oor_rd_beats: got %0d want 2", rq_data.size()); end
    for (int k = 0; k < 2; k++) begin
      total++; if (rq_data[k] !== 32'h0 || rq_resp[k] !== 2'b10) begin bad++;
        $display("FAIL oor_rd_beat%0d: data=%h resp=%b want 0 10", k, rq_data[k], rq_resp[k]); end
    end
    write_burst(32'h1 << MAW, 0, 32'hDEADBEEF, 4'hF, 1'b0, ok, br, bvt);
    total++; if (br !== 2'b10) begin bad++;
      $display("FAIL oor_bresp: got %b want 10", br); end
    read_burst(32'h0, 0, 1'b0, 1'b0, ok);
    total++; if (rq_data[0] !== 32'h5A5A0000 || rq_resp[0] !== 2'b00) begin bad++;
      $display("FAIL oor_alias_intact: got %h resp %b want 5a5a0000 00", rq_data[0], rq_resp[0]); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    axi_arvalid = 1'b0; axi_araddr = '0; axi_arlen = '0; axi_arsize = 3'd2;
    axi_arburst = 2'b01; axi_arid = '0; axi_rready = 1'b0;
    axi_awvalid = 1'b0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = 3'd2;
    axi_awburst = 2'b01; axi_awid = '0; axi_wvalid = 1'b0; axi_wdata = '0;
    axi_wstrb = '0; axi_wlast = 1'b0; axi_bready = 1'b0;
    test_reset();
    test_tie();
    test_write_read();
    test_strobes();
    test_backpressure();
    test_reset_mid_burst();
`ifdef AXI_MEM_RANGE_ERR_EN
    test_range_err();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
